mod12_load_down_counter: RTL

Synchronous mod-N down counter (default N=12, sequence 11→0) with count enable, range-checked parallel load, and cascade outputs. It is the decrementing counterpart of the team's mod-12 loadable up counter. It is used wherever a countdown or timer is needed: load a value, count to zero, then borrow and wrap to MOD-1. Borrow/terminal-count outputs allow chaining stages into multi-digit countdown timers.

---
 rtl/mod12_load_down_counter_if.sv | 39 +++
 rtl/mod12_load_down_counter.sv | 66 ++++++
 2 files changed

// File: rtl/mod12_load_down_counter_if.sv
// Bus bundle for the mod-N loadable down counter.
// Control (en, load, d_in) flows from the master into the counter; count and
// the status/cascade flags flow back. There is no valid/ready handshake: the
// controls are sampled on every rising clock edge, and the outputs are
// meaningful in every cycle.
interface mod12_load_down_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             borrow_out;
  logic             wrap;
  logic             load_err;

  modport master (
    output en,
    output load,
    output d_in,
    input  count,
    input  tc,
    input  borrow_out,
    input  wrap,
    input  load_err
  );

  modport slave (
    input  en,
    input  load,
    input  d_in,
    output count,
    output tc,
    output borrow_out,
    output wrap,
    output load_err
  );
endinterface

// File: rtl/mod12_load_down_counter.sv
// Synchronous mod-MOD down counter with a range-checked parallel load and
// cascade outputs (tc, borrow_out) for chaining countdown stages.
// Edge priority: rst > load > en > hold.
module mod12_load_down_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  mod12_load_down_counter_if.slave bus
);

  // The load bound is compared at WIDTH+1 bits, so MOD = 2^WIDTH is representable
  // and in that case no load is ever rejected.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             load_ok;

  assign load_ok = ({1'b0, bus.d_in} < MOD_W);

  // Next-state: load wins over en; an out-of-range load holds the count and flags an error.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        count_d = bus.d_in;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (count_q == '0) begin
        count_d = LAST;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.wrap       = wrap_q;
  assign bus.load_err   = load_err_q;
  // A pending load never borrows from the next stage.
  assign bus.tc         = (count_q == '0);
  assign bus.borrow_out = bus.en && !bus.load && (count_q == '0);

endmodule
